// File: rtl/sched_pkg.sv
// Shared constants, FSM state type and a one-hot decode helper for the iSLIP scheduler.
package sched_pkg;

    localparam int unsigned NUM_PORTS = 4;
    localparam int unsigned PORT_W    = 2;

    typedef enum logic [2:0] {
        StIdle,
        StRequest,
        StGrant,
        StAccept,
        StIssue
    } sched_state_e;

    function automatic logic [PORT_W-1:0] onehot_to_idx(input logic [NUM_PORTS-1:0] oh);
        logic [PORT_W-1:0] idx;
        idx = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            if (oh[k]) idx = PORT_W'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or after ptr.
module rr_arbiter
    import sched_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    ptr,
    output logic [NUM_PORTS-1:0] gnt
);

    logic [PORT_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = ptr + PORT_W'(k);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/islip_sched.sv
// Single-iteration iSLIP crossbar scheduler: request, grant, accept and issue, one state per clock.
module islip_sched
    import sched_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4  // only 4 is supported
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            sched_en,
    input  logic [NUM_PORTS*NUM_PORTS-1:0]  voq_empty,
    output logic [NUM_PORTS-1:0]            sched_sel_en,
    output logic [NUM_PORTS*PORT_W-1:0]     sched_sel,
    output logic                            busy
);

    sched_state_e state_q, state_d;

    // req_q[i][j]: input i requests output j. grant_q[j][i]: output j grants input i.
    // accept_q[i][j]: input i accepts output j.
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] req_q, grant_q, accept_q;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] req_col, gnt_row, gnt_d, acc_d;
    logic [NUM_PORTS-1:0][PORT_W-1:0]    grant_ptr_q, accept_ptr_q;
    logic [NUM_PORTS-1:0][PORT_W-1:0]    sel_q, sel_d;
    logic [NUM_PORTS-1:0]                sel_en_q, match;
    logic                                busy_q;

    always_comb begin
        req_col = '0;
        gnt_row = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            for (int unsigned j = 0; j < NUM_PORTS; j++) begin
                req_col[j][i] = req_q[i][j];
                gnt_row[i][j] = grant_q[j][i];
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_arb
        rr_arbiter u_grant_arb (
            .req (req_col[p]),
            .ptr (grant_ptr_q[p]),
            .gnt (gnt_d[p])
        );
        rr_arbiter u_accept_arb (
            .req (gnt_row[p]),
            .ptr (accept_ptr_q[p]),
            .gnt (acc_d[p])
        );
    end

    always_comb begin
        match = '0;
        sel_d = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            match[i] = |accept_q[i];
            sel_d[i] = onehot_to_idx(accept_q[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (sched_en) state_d = StRequest;
            StRequest: state_d = StGrant;
            StGrant:   state_d = StAccept;
            StAccept:  state_d = StIssue;
            StIssue:   state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            req_q        <= '0;
            grant_q      <= '0;
            accept_q     <= '0;
            grant_ptr_q  <= '0;
            accept_ptr_q <= '0;
            sel_q        <= '0;
            sel_en_q     <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= (state_d != StIdle);
            sel_en_q <= '0;
            case (state_q)
                StRequest: req_q <= ~voq_empty;
                StGrant:   grant_q <= gnt_d;
                StAccept: begin
                    accept_q <= acc_d;
                    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                        for (int unsigned j = 0; j < NUM_PORTS; j++) begin
                            if (acc_d[i][j]) begin
                                grant_ptr_q[j]  <= PORT_W'(i + 1);
                                accept_ptr_q[i] <= PORT_W'(j + 1);
                            end
                        end
                    end
                end
                StIssue: begin
                    sel_en_q <= match;
                    // An empty match keeps the previous selection visible.
                    if (|match) sel_q <= sel_d;
                end
                default: ;
            endcase
        end
    end

    assign sched_sel_en = sel_en_q;
    assign sched_sel    = sel_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_islip_sched.sv
// Directed bench for islip_sched: table of scheduling rounds plus re-trigger and abort sequences.
module tb_islip_sched;

    logic        clk;
    logic        reset;
    logic        sched_en;
    logic [15:0] voq_empty;
    logic [3:0]  sched_sel_en;
    logic [7:0]  sched_sel;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    islip_sched #(.NUM_PORTS(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .sched_en     (sched_en),
        .voq_empty    (voq_empty),
        .sched_sel_en (sched_sel_en),
        .sched_sel    (sched_sel),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] voq_empty;
        logic [3:0]  exp_en;
        logic [7:0]  exp_sel;
        logic [7:0]  exp_gptr;   // {gp3,gp2,gp1,gp0}
        logic [7:0]  exp_aptr;   // {ap3,ap2,ap1,ap0}
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full round; voq_empty is scrambled after the REQUEST cycle to prove it was latched.
    task automatic run_round(input logic [15:0] ve, output logic [3:0] en_seen,
                             output logic [7:0] sel_seen, output logic early,
                             output logic busy_ok, output logic busy_end);
        @(negedge clk);
        voq_empty = ve;
        sched_en  = 1'b1;
        @(posedge clk); #1;
        sched_en = 1'b0;
        early    = 1'b0;
        busy_ok  = busy;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            if (k == 1) voq_empty = ~ve;
            early   = early | (sched_sel_en != 4'b0000);
            busy_ok = busy_ok & busy;
        end
        @(posedge clk); #1;
        en_seen  = sched_sel_en;
        sel_seen = sched_sel;
        busy_end = busy;
    endtask

    logic [3:0] en_seen;
    logic [7:0] sel_seen;
    logic       early, busy_ok, busy_end;
    logic [7:0] gptr, aptr;
    int         pulses, pulse_at, late_busy;

    initial begin
        vecs[0] = '{16'h0000, 4'b0001, 8'h00, 8'h01, 8'h01};
        vecs[1] = '{16'h0000, 4'b0011, 8'h01, 8'h06, 8'h06};
        vecs[2] = '{16'hF7FF, 4'b0100, 8'h30, 8'hC6, 8'h06};
        vecs[3] = '{16'hFFFF, 4'b0000, 8'h30, 8'hC6, 8'h06};
        vecs[4] = '{16'h0000, 4'b1111, 8'hC6, 8'h1B, 8'h1B};
        vecs[5] = '{16'h0FFE, 4'b1000, 8'h00, 8'h18, 8'h5B};

        reset     = 1'b1;
        sched_en  = 1'b0;
        voq_empty = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 16'(busy), 16'h0);
        check("reset_sel_en", 16'(sched_sel_en), 16'h0);
        check("reset_sel", 16'(sched_sel), 16'h0);
        gptr = dut.grant_ptr_q;
        aptr = dut.accept_ptr_q;
        check("reset_ptrs", {gptr, aptr}, 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            run_round(vecs[v].voq_empty, en_seen, sel_seen, early, busy_ok, busy_end);
            check($sformatf("v%0d_early_pulse", v), 16'(early), 16'h0);
            check($sformatf("v%0d_busy_in_round", v), 16'(busy_ok), 16'h1);
            check($sformatf("v%0d_busy_after", v), 16'(busy_end), 16'h0);
            check($sformatf("v%0d_sel_en", v), 16'(en_seen), 16'(vecs[v].exp_en));
            check($sformatf("v%0d_sel", v), 16'(sel_seen), 16'(vecs[v].exp_sel));
            gptr = dut.grant_ptr_q;
            aptr = dut.accept_ptr_q;
            check($sformatf("v%0d_grant_ptr", v), 16'(gptr), 16'(vecs[v].exp_gptr));
            check($sformatf("v%0d_accept_ptr", v), 16'(aptr), 16'(vecs[v].exp_aptr));
            @(posedge clk); #1;
            check($sformatf("v%0d_pulse_width", v), 16'(sched_sel_en), 16'h0);
            check($sformatf("v%0d_sel_hold", v), 16'(sched_sel), 16'(vecs[v].exp_sel));
        end

        // sched_en re-pulsed while in GRANT must be dropped.
        @(negedge clk);
        voq_empty = 16'h0000;
        sched_en  = 1'b1;
        @(posedge clk); #1;
        sched_en  = 1'b0;
        pulses    = 0;
        pulse_at  = -1;
        late_busy = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (c == 1) sched_en = 1'b1;
            if (c == 2) sched_en = 1'b0;
            if (sched_sel_en != 4'b0000) begin
                pulses++;
                pulse_at = c;
            end
            if (c == 3) check("retrig_busy_issue", 16'(busy), 16'h1);
            if (c == 4) check("retrig_busy_fall", 16'(busy), 16'h0);
            if (c > 4 && busy) late_busy++;
        end
        check("retrig_pulse_count", 16'(pulses), 16'h1);
        check("retrig_pulse_cycle", 16'(pulse_at), 16'h4);
        check("retrig_no_queued_round", 16'(late_busy), 16'h0);

        // Reset during ACCEPT aborts the round.
        @(negedge clk);
        voq_empty = 16'h0000;
        sched_en  = 1'b1;
        @(posedge clk); #1;
        sched_en = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("abort_busy", 16'(busy), 16'h0);
        gptr = dut.grant_ptr_q;
        aptr = dut.accept_ptr_q;
        check("abort_ptrs", {gptr, aptr}, 16'h0000);
        check("abort_sel", 16'(sched_sel), 16'h0);
        @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (sched_sel_en != 4'b0000 || busy) pulses++;
        end
        check("abort_no_issue", 16'(pulses), 16'h0);

        run_round(16'h0000, en_seen, sel_seen, early, busy_ok, busy_end);
        check("post_abort_sel_en", 16'(en_seen), 16'h0001);
        check("post_abort_sel", 16'(sel_seen), 16'h0000);
        gptr = dut.grant_ptr_q;
        aptr = dut.accept_ptr_q;
        check("post_abort_ptrs", {gptr, aptr}, 16'h0101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/islip_sched.md
ISLIP_SCHED -- requirements
Module: islip_sched

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, giving crossbar inputs = outputs; only 4 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port sched_en  input  1  start one scheduling round; sampled only in IDLE.
REQ-005 SHALL have port voq_empty  input  16  bit 4*i+j high = input i VOQ for output j empty.
REQ-006 SHALL have port sched_sel_en  output  4  bit i high = input i dequeues this cycle.
REQ-007 SHALL have port sched_sel  output  8  bits [2i+1:2i] = output port matched to input i.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-009 SHALL implement FSM IDLE -> REQUEST -> GRANT -> ACCEPT -> ISSUE -> IDLE, advancing one state per clock; only IDLE waits, and only for sched_en.
REQ-010 SHALL latch req = ~voq_empty on the REQUEST cycle; voq_empty changes after that cycle SHALL not affect the round.
REQ-011 GRANT: each output j SHALL grant the first requesting input at or after grant_ptr[j], searching modulo 4; no requester means no grant.
REQ-012 ACCEPT: each input i SHALL accept the first granting output at or after accept_ptr[i], searching modulo 4; each input accepts at most one output, and each output is matched to at most one input.
REQ-013 Pointer update, accepted pairs only: grant_ptr[j] <= (i+1) mod 4 and accept_ptr[i] <= (j+1) mod 4; unaccepted grants leave pointers unchanged.
REQ-014 ISSUE: sched_sel_en SHALL be the registered accept vector for exactly one cycle; otherwise 4'b0000.
REQ-015 ISSUE: sched_sel[2i+1:2i] SHALL be the accepted output for matched inputs and 2'b00 for unmatched inputs; the value SHALL hold until the next ISSUE.
REQ-016 Latency: sched_en high in IDLE at edge T SHALL produce sched_sel_en at the cycle after edge T+4; busy SHALL be high for REQUEST through ISSUE.
REQ-017 sched_en while busy SHALL be ignored, with no queuing of the request.
REQ-018 All-empty request (voq_empty = 16'hFFFF) SHALL run the full round, issue sched_sel_en = 0, and leave all pointers unchanged.
REQ-019 All outputs SHALL be registered; there SHALL be no combinational path from input to output.

Reset
REQ-020 Reset SHALL set state to IDLE and clear all pointers to 0, sched_sel_en to 0, sched_sel to 0, busy to 0, and the latched req/grant/accept registers to 0.
REQ-021 Reset asserted mid-round SHALL abort the round immediately with no ISSUE pulse and no pointer update.

Structure
REQ-022 SHALL place NUM_PORTS, PORT_W = 2, and the FSM state enum in shared package sched_pkg.
REQ-023 SHALL use sub-module rr_arbiter (4-bit request, 2-bit pointer, one-hot grant, combinational), instantiated 4x for grant and 4x for accept.

Verification
REQ-024 After reset, voq_empty = 16'h0000, pulse sched_en -> 4 cycles later sched_sel_en = 4'b0001, sched_sel = 8'h00; grant_ptr[0] = 1, accept_ptr[0] = 1.
REQ-025 Second round, same input -> sched_sel_en = 4'b0011, sched_sel = 8'h01 (input0->out1, input1->out0).
REQ-026 voq_empty = 16'hF7FF -> sched_sel_en = 4'b0100, sched_sel = 8'h30; grant_ptr[3] = 3, accept_ptr[2] = 0.
REQ-027 voq_empty = 16'hFFFF -> sched_sel_en = 0, sched_sel keeps its previous value, pointers unchanged.
REQ-028 sched_en re-pulsed during GRANT -> ignored; exactly one ISSUE pulse; busy falls one cycle after ISSUE.
REQ-029 reset asserted during ACCEPT -> no ISSUE pulse, pointers = 0; the next round matches the first post-reset result.
